scoreboard_regfile: RTL and testbench
=====================================

SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 5, register index width; NUM_REGS = 2**ADDR_W.
REQ-003 Parameter ZERO_R0, default 1; when 1, register 0 reads as zero, is never written and is never busy.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-006 rs1_addr_i / rs2_addr_i  in  ADDR_W each  read port indices.
REQ-007 rs1_data_o / rs2_data_o  out  DATA_W each  read data.
REQ-008 rs1_busy_o / rs2_busy_o  out  1 each  the read register has an outstanding writer.
REQ-009 issue_valid_i  in  1  request to mark issue_addr_i pending.
REQ-010 issue_addr_i  in  ADDR_W  destination being issued.
REQ-011 issue_ready_o  out  1  issue is accepted this cycle.
REQ-012 wb_valid_i  in  1  writeback strobe.
REQ-013 wb_addr_i  in  ADDR_W  writeback index.
REQ-014 wb_data_i  in  DATA_W  writeback data.
REQ-015 ready_o  out  1  initialisation sweep complete, block operational.
REQ-016 busy_cnt_o  out  ADDR_W+1  number of busy registers.

Function
REQ-017 The FSM SHALL have two states: INIT and RUN.
REQ-018 In INIT, the FSM SHALL write zero to entry idx and increment idx, one entry per cycle, from 0 to NUM_REGS-1.
REQ-019 The FSM SHALL go INIT->RUN on the cycle that writes entry NUM_REGS-1; ready_o SHALL be 1 exactly NUM_REGS cycles after reset release.
REQ-020 In INIT: ready_o=0, issue_ready_o=0, wb_valid_i and issue_valid_i ignored, read data 0, busy outputs 0.
REQ-021 In RUN, reads SHALL be combinational: rsN_data_o = entry[rsN_addr_i].
REQ-022 Write-first bypass: when wb_valid_i=1 and wb_addr_i==rsN_addr_i, rsN_data_o SHALL equal wb_data_i and rsN_busy_o SHALL be 0 in the same cycle.
REQ-023 When ZERO_R0=1 and rsN_addr_i==0: data 0 and busy 0, regardless of bypass.
REQ-024 On a RUN rising edge with wb_valid_i=1 and a writable address, the entry SHALL be written and its busy bit cleared.
REQ-025 issue_ready_o = RUN and (busy[issue_addr_i]==0 or (wb_valid_i and wb_addr_i==issue_addr_i)); WAW to a pending register without a same-cycle writeback SHALL stall.
REQ-026 Accepted issue (issue_valid_i and issue_ready_o) SHALL set busy[issue_addr_i] at the edge.
REQ-027 When issue and writeback target the same address in the same cycle, the data write SHALL happen and the busy bit SHALL end at 1 (set wins).
REQ-028 Issue to register 0 with ZERO_R0=1 SHALL be accepted with no state change.
REQ-029 Writeback to a non-busy register SHALL still write data; the busy bit stays 0.
REQ-030 busy_cnt_o SHALL be registered and equal the popcount of the busy vector after each edge; it SHALL never exceed NUM_REGS-ZERO_R0.

Reset
REQ-031 Asserting rst_n_i at any time SHALL immediately force: FSM=INIT, idx=0, all busy bits=0, busy_cnt_o=0, ready_o=0, issue_ready_o=0.
REQ-032 Read data SHALL be 0 while in reset and during INIT, including when reset occurs mid-INIT or mid-RUN; the sweep then restarts from 0.
REQ-033 The data array SHALL NOT be asynchronously reset; the INIT sweep clears it.

Structure
REQ-034 Package regfile_pkg SHALL hold the FSM state typedef (INIT, RUN) and default DATA_W/ADDR_W constants.
REQ-035 Busy-bit vector, popcount and set/clear priority SHALL be one sub-module, sb_busy_vec, parametrised on ADDR_W.

Verification
REQ-036 Reset release -> ready_o rises after exactly 32 cycles (defaults); reading every index returns 0.
REQ-037 Issue r5; next cycle rs1_addr_i=5 -> rs1_busy_o=1; writeback r5=0xDEADBEEF -> same-cycle rs1_data_o=0xDEADBEEF, rs1_busy_o=0; next cycle busy_cnt_o=0.
REQ-038 r7 busy; issue r7 without writeback -> issue_ready_o=0; with same-cycle wb r7 -> issue_ready_o=1, r7 data updated, busy stays 1.
REQ-039 Write r0=0x1234 and issue r0 -> r0 reads 0, busy 0, busy_cnt_o unchanged.
REQ-040 Issue r1..r31 over 31 cycles -> busy_cnt_o=31; assert rst_n_i mid-run -> busy_cnt_o=0 and ready_o=0 immediately; sweep repeats 32 cycles.
REQ-041 Reset asserted at INIT idx=10 -> idx restarts at 0; ready_o rises 32 cycles after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizes for the scoreboarded register file.
//   state_e       - two-state sequencer: INIT (clearing sweep) and RUN (operational)
//   DEF_DATA_W    - default register data width
//   DEF_ADDR_W    - default register index width
package regfile_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

endpackage : regfile_pkg

// File: rtl/sb_busy_vec.sv
// sb_busy_vec: per-register busy bits with a registered popcount.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_set_en/addr  - mark a register as having an outstanding writer
//   i_clr_en/addr  - writeback retires the outstanding writer
//   o_busy         - current busy vector, one bit per register
//   o_busy_cnt     - number of busy registers, updated on the same edge as o_busy
// When set and clear hit the same register in one cycle the set wins: the
// writeback retires the old producer while the new issue becomes the owner.
module sb_busy_vec #(
  parameter int ADDR_W  = regfile_pkg::DEF_ADDR_W,
  parameter int ZERO_R0 = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_set_en,
  input  logic [ADDR_W-1:0]        i_set_addr,
  input  logic                     i_clr_en,
  input  logic [ADDR_W-1:0]        i_clr_addr,
  output logic [(2**ADDR_W)-1:0]   o_busy,
  output logic [ADDR_W:0]          o_busy_cnt
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [ADDR_W:0]     r_cnt;
  logic [ADDR_W:0]     w_cnt_nxt;

  // NOTE: every variable written in always_comb gets a default on entry, so
  // no path leaves it holding a stale value and no latch is inferred.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set_en) w_busy_nxt[i_set_addr] = 1'b1;
    if (ZERO_R0 != 0) w_busy_nxt[0] = 1'b0;
  end

  // Count the next vector so the registered count matches r_busy after each edge.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_cnt_nxt = w_cnt_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_busy     = r_busy;
  assign o_busy_cnt = r_cnt;

endmodule : sb_busy_vec

// File: rtl/scoreboard_regfile.sv
// scoreboard_regfile: 2-read / 1-write register file with a busy scoreboard.
//   clk_i, rst_n_i            - clock, asynchronous active-low reset
//   rs1/rs2_addr_i            - combinational read indices
//   rs1/rs2_data_o, _busy_o   - read data (write-first bypass) and pending flag
//   issue_valid_i/addr_i      - mark a destination as pending
//   issue_ready_o             - issue accepted this cycle (stalls WAW on a busy reg)
//   wb_valid_i/addr_i/data_i  - writeback: writes data and retires the busy bit
//   ready_o                   - clearing sweep finished, block operational
//   busy_cnt_o                - registered count of busy registers
// After reset an INIT sweep zeroes one entry per cycle; the data array itself
// has no reset, so outputs are forced to zero until the sweep completes.
module scoreboard_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  output logic              issue_ready_o,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              ready_o,
  output logic [ADDR_W:0]   busy_cnt_o
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS-1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   w_idx_nxt;
  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;
  logic                w_run;
  logic                w_issue_fire;
  logic                w_wb_fire;
  logic                w_rs1_byp;
  logic                w_rs2_byp;

  function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
    return !((ZERO_R0 != 0) && (addr == '0));
  endfunction

  // ---------------- sequencer ----------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Leave INIT on the same edge that clears the last entry.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      ST_INIT: begin
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_RUN;
          w_idx_nxt   = '0;
        end
      end
      ST_RUN: ;
      default: begin
        w_state_nxt = ST_INIT;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign w_run   = (r_state == ST_RUN);
  assign ready_o = w_run;

  // ---------------- data array ----------------
  // NOTE: the array is deliberately left out of the async reset; the INIT
  // sweep zeroes it, which keeps it mappable onto plain RAM/flop arrays.
  always_ff @(posedge clk_i) begin
    if (!w_run) begin
      r_mem[r_idx] <= '0;
    end else if (w_wb_fire) begin
      r_mem[wb_addr_i] <= wb_data_i;
    end
  end

  // ---------------- scoreboard ----------------
  // A same-cycle writeback to the target retires the old producer, so the
  // new issue may proceed instead of stalling on WAW.
  assign issue_ready_o = w_run &&
                         (!w_busy[issue_addr_i] ||
                          (wb_valid_i && (wb_addr_i == issue_addr_i)));
  assign w_issue_fire  = issue_valid_i && issue_ready_o;
  assign w_wb_fire     = w_run && wb_valid_i && is_writable(wb_addr_i);

  sb_busy_vec #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_busy (
    .i_clk      (clk_i),
    .i_rst_n    (rst_n_i),
    .i_set_en   (w_issue_fire),
    .i_set_addr (issue_addr_i),
    .i_clr_en   (w_wb_fire),
    .i_clr_addr (wb_addr_i),
    .o_busy     (w_busy),
    .o_busy_cnt (busy_cnt_o)
  );

  // ---------------- read ports ----------------
  assign w_rs1_byp = wb_valid_i && (wb_addr_i == rs1_addr_i);
  assign w_rs2_byp = wb_valid_i && (wb_addr_i == rs2_addr_i);

  // Priority: not running -> 0; hard-wired r0 -> 0; bypass; array.
  always_comb begin
    rs1_data_o = '0;
    rs1_busy_o = 1'b0;
    if (w_run && is_writable(rs1_addr_i)) begin
      if (w_rs1_byp) begin
        rs1_data_o = wb_data_i;
      end else begin
        rs1_data_o = r_mem[rs1_addr_i];
        rs1_busy_o = w_busy[rs1_addr_i];
      end
    end
  end

  always_comb begin
    rs2_data_o = '0;
    rs2_busy_o = 1'b0;
    if (w_run && is_writable(rs2_addr_i)) begin
      if (w_rs2_byp) begin
        rs2_data_o = wb_data_i;
      end else begin
        rs2_data_o = r_mem[rs2_addr_i];
        rs2_busy_o = w_busy[rs2_addr_i];
      end
    end
  end

endmodule : scoreboard_regfile

// File: tb/tb_scoreboard_regfile.sv
// Testbench for scoreboard_regfile (default parameters).
module tb_scoreboard_regfile;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ready;
  logic [5:0]  busy_cnt;

  scoreboard_regfile dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .rs1_addr_i    (rs1_addr),
    .rs2_addr_i    (rs2_addr),
    .rs1_data_o    (rs1_data),
    .rs2_data_o    (rs2_data),
    .rs1_busy_o    (rs1_busy),
    .rs2_busy_o    (rs2_busy),
    .issue_valid_i (issue_valid),
    .issue_addr_i  (issue_addr),
    .issue_ready_o (issue_ready),
    .wb_valid_i    (wb_valid),
    .wb_addr_i     (wb_addr),
    .wb_data_i     (wb_data),
    .ready_o       (ready),
    .busy_cnt_o    (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {K_D1, K_D2, K_B1, K_B2, K_IRDY, K_RDY, K_CNT} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  function automatic logic [31:0] sample(input kind_e k);
    case (k)
      K_D1:    return rs1_data;
      K_D2:    return rs2_data;
      K_B1:    return 32'(rs1_busy);
      K_B2:    return 32'(rs2_busy);
      K_IRDY:  return 32'(issue_ready);
      K_RDY:   return 32'(ready);
      default: return 32'(busy_cnt);
    endcase
  endfunction

  // Monitor: outputs are stable mid-cycle; compare everything queued for this cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = q.pop_front();
      act = sample(e.kind);
      n_total++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic expect_v(input kind_e k, input logic [31:0] v, input string nm);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_addr = '0;
    wb_valid    = 1'b0; wb_addr    = '0; wb_data = '0;
  endtask

  // Called right after reset release (posedge+1). Drives writeback/issue
  // noise that INIT must ignore and checks ready rises after exactly 32 edges.
  task automatic sweep_check(input string tag);
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_addr = 5'd4;
    rs1_addr = 5'd3; rs2_addr = 5'd4;
    for (int i = 0; i < 32; i++) begin
      expect_v(K_RDY,  32'd0, {tag, "_ready_low"});
      expect_v(K_IRDY, 32'd0, {tag, "_issue_ready_low"});
      if (i % 8 == 0) begin
        expect_v(K_D1, 32'd0, {tag, "_init_rd1_zero"});
        expect_v(K_B2, 32'd0, {tag, "_init_busy2_zero"});
      end
      step();
    end
    idle_inputs();
    expect_v(K_RDY, 32'd1, {tag, "_ready_at_32"});
    expect_v(K_CNT, 32'd0, {tag, "_cnt_after_init"});
    expect_v(K_D1,  32'd0, {tag, "_r3_not_written"});
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    idle_inputs();
    #2;
    rs1_addr = 5'd9;
    expect_v(K_RDY,  32'd0, "rst_ready");
    expect_v(K_IRDY, 32'd0, "rst_issue_ready");
    expect_v(K_CNT,  32'd0, "rst_cnt");
    expect_v(K_D1,   32'd0, "rst_rd1");
    step();
    step();
    rst_n = 1'b1;
    sweep_check("init");

    // Every index reads zero and idle after the sweep.
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      expect_v(K_D1, 32'd0, "sweep_rd1_zero");
      expect_v(K_D2, 32'd0, "sweep_rd2_zero");
      expect_v(K_B1, 32'd0, "sweep_busy1_zero");
      step();
    end

    // Issue r5, then writeback with same-cycle bypass.
    issue_valid = 1'b1; issue_addr = 5'd5;
    expect_v(K_IRDY, 32'd1, "r5_issue_ready");
    step();
    issue_valid = 1'b0;
    rs1_addr = 5'd5;
    expect_v(K_B1,  32'd1, "r5_busy");
    expect_v(K_CNT, 32'd1, "r5_cnt1");
    step();
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    expect_v(K_D1,  32'hDEAD_BEEF, "r5_bypass_data");
    expect_v(K_B1,  32'd0, "r5_bypass_busy");
    expect_v(K_CNT, 32'd1, "r5_cnt_before_edge");
    step();
    idle_inputs();
    expect_v(K_D1,  32'hDEAD_BEEF, "r5_stored");
    expect_v(K_B1,  32'd0, "r5_busy_cleared");
    expect_v(K_CNT, 32'd0, "r5_cnt0");
    step();

    // WAW stall on r7, then same-cycle writeback lets the issue through.
    issue_valid = 1'b1; issue_addr = 5'd7;
    step();
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    expect_v(K_IRDY, 32'd0, "r7_waw_stall");
    step();
    expect_v(K_CNT, 32'd1, "r7_cnt_after_stall");
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_0077;
    expect_v(K_IRDY, 32'd1, "r7_issue_with_wb");
    expect_v(K_D1,   32'h0000_0077, "r7_bypass1");
    expect_v(K_D2,   32'h0000_0077, "r7_bypass2");
    expect_v(K_B2,   32'd0, "r7_bypass_busy2");
    step();
    idle_inputs();
    expect_v(K_D1,  32'h0000_0077, "r7_data_written");
    expect_v(K_B1,  32'd1, "r7_set_wins");
    expect_v(K_CNT, 32'd1, "r7_cnt_stays1");
    step();
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_0700;
    step();
    idle_inputs();
    expect_v(K_CNT, 32'd0, "r7_retired_cnt");
    expect_v(K_D1,  32'h0000_0700, "r7_second_wb");
    step();

    // r0 is hard-wired: write and issue have no visible effect.
    rs1_addr = 5'd0; rs2_addr = 5'd9;
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_1234;
    issue_valid = 1'b1; issue_addr = 5'd0;
    expect_v(K_D1,   32'd0, "r0_no_bypass");
    expect_v(K_B1,   32'd0, "r0_busy");
    expect_v(K_IRDY, 32'd1, "r0_issue_accepted");
    step();
    idle_inputs();
    expect_v(K_D1,  32'd0, "r0_reads_zero");
    expect_v(K_CNT, 32'd0, "r0_cnt_unchanged");
    // Writeback to a non-busy register still writes.
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_00A5;
    step();
    idle_inputs();
    expect_v(K_D2,  32'h0000_00A5, "r9_nonbusy_write");
    expect_v(K_B2,  32'd0, "r9_stays_idle");
    expect_v(K_CNT, 32'd0, "r9_cnt0");
    step();

    // Fill r1..r31, then reset mid-run.
    for (int a = 1; a < 32; a++) begin
      issue_valid = 1'b1; issue_addr = 5'(a);
      expect_v(K_IRDY, 32'd1, "fill_issue_ready");
      step();
    end
    issue_valid = 1'b1; issue_addr = 5'd1;
    rs1_addr = 5'd5;
    expect_v(K_CNT,  32'd31, "fill_cnt31");
    expect_v(K_IRDY, 32'd0, "fill_r1_stall");
    expect_v(K_B1,   32'd1, "fill_r5_busy");
    step();
    idle_inputs();
    #2;
    rst_n = 1'b0;
    expect_v(K_CNT,  32'd0, "midrun_rst_cnt");
    expect_v(K_RDY,  32'd0, "midrun_rst_ready");
    expect_v(K_IRDY, 32'd0, "midrun_rst_issue_ready");
    expect_v(K_D1,   32'd0, "midrun_rst_rd1");
    step();
    rst_n = 1'b1;
    sweep_check("rerun");
    rs1_addr = 5'd5; rs2_addr = 5'd7;
    expect_v(K_D1, 32'd0, "rerun_r5_cleared");
    expect_v(K_D2, 32'd0, "rerun_r7_cleared");
    expect_v(K_B1, 32'd0, "rerun_r5_idle");
    step();

    // Reset at INIT idx=10: the sweep restarts from zero.
    #2;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (10) step();
    #2;
    rst_n = 1'b0;
    expect_v(K_RDY, 32'd0, "midinit_rst_ready");
    expect_v(K_CNT, 32'd0, "midinit_rst_cnt");
    step();
    rst_n = 1'b1;
    sweep_check("midinit");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_total++;
      n_bad++;
      $display("FAIL drain: %0d checks pending, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_scoreboard_regfile
